// File: rtl/speed_cmd_arbiter.sv
// speed_cmd_arbiter: button/keyboard round-robin arbiter onto the shared speed code, tick rate-limited
// Define SPEED_ARB_AUTOREPEAT_EN to let a held button re-request after every cooldown.
module speed_cmd_arbiter #(
  parameter int SPEED_MIN     = 0,
  parameter int SPEED_MAX     = 8,
  parameter int SPEED_DEFAULT = 3,
  parameter int HOLD_TICKS    = 2,
  parameter int MSG_TICKS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       kb_valid,
  input  logic [7:0] kb_code,
  output logic [3:0] speed_code,
  output logic [1:0] grant,
  output logic       at_limit,
  output logic       disp_sel,
  output logic [7:0] msg_code,
  output logic       busy
);
  localparam logic [7:0] KB_UP     = 8'h2B;
  localparam logic [7:0] KB_DOWN   = 8'h1B;
  localparam logic [7:0] KB_PRESET = 8'h21;
  localparam logic [3:0] L_MIN  = 4'(SPEED_MIN);
  localparam logic [3:0] L_MAX  = 4'(SPEED_MAX);
  localparam logic [3:0] L_DEF  = 4'(SPEED_DEFAULT);
  localparam logic [3:0] L_HOLD = 4'(HOLD_TICKS);
  localparam logic [3:0] L_MSG  = 4'(MSG_TICKS);

  typedef enum logic {IDLE, COOLDOWN} state_t;

  state_t     r_state;
  logic [3:0] r_speed, r_cool, r_msg_cnt;
  logic [1:0] r_grant;
  logic       r_at_limit, r_disp, r_pend_v, r_last_kb;
  logic [7:0] r_msg, r_pend;

  logic       w_known, w_up, w_dn, w_btn_req, w_arb, w_use_kb;
  logic       w_step_up, w_step_dn, w_preset, w_clip;
  logic [3:0] w_next_speed;

  assign w_known = (kb_code == KB_UP) || (kb_code == KB_DOWN) || (kb_code == KB_PRESET);
  assign w_up    = btn_up & ~btn_down;
  assign w_dn    = btn_down & ~btn_up;

`ifdef SPEED_ARB_AUTOREPEAT_EN
  assign w_btn_req = w_up | w_dn;
`else
  logic r_mask;
  assign w_btn_req = (w_up | w_dn) & ~r_mask;
`endif

  assign w_arb    = tick && (r_state == IDLE) && (w_btn_req || r_pend_v);
  // keyboard wins a tie only when the button had the previous grant
  assign w_use_kb = r_pend_v & (~w_btn_req | ~r_last_kb);

  always_comb begin
    w_step_up    = w_use_kb ? (r_pend == KB_UP)   : w_up;
    w_step_dn    = w_use_kb ? (r_pend == KB_DOWN) : w_dn;
    w_preset     = w_use_kb & (r_pend == KB_PRESET);
    w_clip       = (w_step_up & (r_speed == L_MAX)) | (w_step_dn & (r_speed == L_MIN));
    w_next_speed = w_preset ? L_DEF :
                   w_clip ? r_speed :
                   w_step_up ? r_speed + 4'd1 :
                   w_step_dn ? r_speed - 4'd1 : r_speed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_speed    <= L_DEF;
      r_cool     <= '0;
      r_grant    <= '0;
      r_at_limit <= 1'b0;
      r_last_kb  <= 1'b1;
      r_pend_v   <= 1'b0;
      r_pend     <= '0;
      r_disp     <= 1'b0;
      r_msg      <= '0;
      r_msg_cnt  <= '0;
    end else begin
      r_grant    <= '0;
      r_at_limit <= 1'b0;
      if (w_arb) begin
        r_speed    <= w_next_speed;
        r_grant    <= {w_use_kb, ~w_use_kb};
        r_at_limit <= w_clip;
        r_last_kb  <= w_use_kb;
        r_cool     <= L_HOLD;
        r_state    <= COOLDOWN;
      end else if (tick && r_state == COOLDOWN) begin
        r_cool <= r_cool - 4'd1;
        if (r_cool == 4'd1) r_state <= IDLE;
      end
      // a fresh recognised code overrides the clear of the one being granted
      if (kb_valid && w_known) begin
        r_pend_v <= 1'b1;
        r_pend   <= kb_code;
      end else if (w_arb && w_use_kb) begin
        r_pend_v <= 1'b0;
      end
      if (w_arb && w_use_kb) begin
        r_disp    <= 1'b1;
        r_msg     <= r_pend;
        r_msg_cnt <= L_MSG;
      end else if (tick && r_disp) begin
        r_msg_cnt <= r_msg_cnt - 4'd1;
        if (r_msg_cnt == 4'd1) r_disp <= 1'b0;
      end
    end
  end

`ifndef SPEED_ARB_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) r_mask <= 1'b0;
    else if (w_arb && !w_use_kb) r_mask <= 1'b1;
    else if (tick && r_state == IDLE && !(w_up || w_dn)) r_mask <= 1'b0;
  end
`endif

  assign speed_code = r_speed;
  assign grant      = r_grant;
  assign at_limit   = r_at_limit;
  assign disp_sel   = r_disp;
  assign msg_code   = r_msg;
  assign busy       = (r_state == COOLDOWN);
endmodule
